// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH, unsigned or signed.
// Signed operands are multiplied as magnitudes; the result is negated at the end.
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      count_q;
  logic               neg_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] addend;

  // Unsigned WIDTH-bit magnitude keeps the most-negative value representable.
  always_comb begin
    mag_a  = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b  = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
    addend = {{WIDTH{1'b0}}, mcand_q} << count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            neg_q    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q    <= '0;
            count_q  <= '0;
            busy     <= 1'b1;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + addend;
          end
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          product <= neg_q ? (~acc_q + 1'b1) : acc_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed WIDTH=4 scenarios and random WIDTH=8 runs
// checked against a plain-arithmetic reference model.
module tb_seq_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, sm4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] prod4;
  logic       start8, sm8, busy8, done8;
  logic [7:0] a8, b8;
  logic [15:0] prod8;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  function automatic logic [15:0] model8(logic [7:0] x, logic [7:0] y, logic sm);
    int xi, yi;
    xi = sm ? int'($signed(x)) : int'(x);
    yi = sm ? int'($signed(y)) : int'(y);
    return 16'(xi * yi);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // One WIDTH=4 operation; operands are scrambled while busy to show they are not re-sampled.
  task automatic op4(input string name, input logic [3:0] x, input logic [3:0] y,
                     input logic sm, input logic [7:0] exp);
    int n = 0;
    int bc = 0;
    @(negedge clk);
    a4 = x; b4 = y; sm4 = sm; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    while (!done4 && n < 20) begin
      if (busy4) bc++;
      a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, n, 5);
    chk({name, "_busy_cycles"}, bc, 5);
    chk({name, "_product"}, prod4, exp);
    chk({name, "_busy_at_done"}, busy4, 0);
    @(negedge clk);
    chk({name, "_done_drop"}, done4, 0);
    chk({name, "_product_hold"}, prod4, exp);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    #2 rst = 1'b1;
    #2;
    chk("reset_busy4", busy4, 0);
    chk("reset_done4", done4, 0);
    chk("reset_prod4", prod4, 0);
    chk("reset_busy8", busy8, 0);
    chk("reset_prod8", prod8, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    op4("u_6x14", 4'b0110, 4'b1110, 1'b0, 8'h54);
    op4("u_15x15", 4'b1111, 4'b1111, 1'b0, 8'hE1);
    op4("u_0x11", 4'b0000, 4'b1011, 1'b0, 8'h00);
  endtask

  task automatic test_signed;
    op4("s_6xm2", 4'b0110, 4'b1110, 1'b1, 8'hF4);
    op4("s_m8xm8", 4'b1000, 4'b1000, 1'b1, 8'h40);
    op4("s_m8x7", 4'b1000, 4'b0111, 1'b1, 8'hC8);
  endtask

  task automatic test_back_to_back;
    int n = 0;
    @(negedge clk);
    a4 = 4'b0110; b4 = 4'b1110; sm4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    // Raised before the FIN edge and held through the done cycle.
    a4 = 4'b0111; b4 = 4'b0101; sm4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    chk("b2b_first_done", done4, 1);
    chk("b2b_first_product", prod4, 8'h54);
    chk("b2b_busy_low_in_done", busy4, 0);
    @(negedge clk);
    start4 = 1'b0;
    chk("b2b_accept_busy", busy4, 1);
    chk("b2b_accept_done_low", done4, 0);
    chk("b2b_product_kept", prod4, 8'h54);
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_latency", n, 5);
    chk("b2b_second_product", prod4, 8'h23);
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int n = 0;
    int dones = 0;
    @(negedge clk);
    a4 = 4'b0111; b4 = 4'b0011; sm4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    n = 1;
    a4 = 4'b0010; b4 = 4'b0110; sm4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    n = 2;
    start4 = 1'b0;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ignore_latency", n, 5);
    chk("ignore_product", prod4, 8'h15);
    repeat (12) begin
      @(negedge clk);
      if (done4) dones++;
    end
    chk("ignore_no_second_done", dones, 0);
    chk("ignore_idle", busy4, 0);
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    @(negedge clk);
    a4 = 4'b0101; b4 = 4'b0011; sm4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_busy", busy4, 0);
    chk("rstmid_done", done4, 0);
    chk("rstmid_product", prod4, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done4) dones++;
    end
    chk("rstmid_no_done", dones, 0);
    chk("rstmid_product_stays", prod4, 0);
    op4("rstmid_fresh", 4'b0101, 4'b0011, 1'b0, 8'h0F);
  endtask

  task automatic test_random8;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] x, y;
      logic sm;
      logic [15:0] exp;
      int n = 0;
      x = 8'($urandom); y = 8'($urandom); sm = 1'($urandom);
      if (i == 0) begin x = 8'h80; y = 8'h80; sm = 1'b1; end
      if (i == 1) begin x = 8'hFF; y = 8'hFF; sm = 1'b0; end
      exp = model8(x, y, sm);
      @(negedge clk);
      a8 = x; b8 = y; sm8 = sm; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      while (!done8 && n < 30) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        @(negedge clk);
        n++;
      end
      chk($sformatf("rand8_%0d_latency", i), n, 9);
      chk($sformatf("rand8_%0d_product", i), prod8, exp);
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid;
    test_random8;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential shift-and-add multiplier; successor to the combinational 4-bit multiplier.
- Accepts a WIDTH x WIDTH operand pair on a start pulse and iterates one partial product per clock. Returns a 2*WIDTH product with a one-cycle done strobe.
- Supports both unsigned and two's-complement signed operands, selected per operation.
- Sits as a shared arithmetic unit behind a simple start/done handshake.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..32); product width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- signed_mode  input  1  0 = unsigned, 1 = two's-complement signed; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle strobe marking a new, valid product.
- product  output  2*WIDTH  result register; holds its value until the next done.

Behaviour:
- Reset: one clock domain (clk), reset is asynchronous and active-high on rst.
  - Immediately forces state=IDLE, busy=0, done=0, product=0, and clears the internal counter, accumulator and operand registers.
  - Reset mid-operation aborts the operation with no done; no partial result is visible.
- States: IDLE, CALC, FIN.
- IDLE:
  - done is low unless it was set by the preceding FIN edge.
  - On an edge with start=1, latch signed_mode, the operand magnitudes |a| and |b|, and neg = signed_mode & (a[MSB]^b[MSB]).
  - In the same edge: clear the accumulator, set count=0, busy=1, go to CALC.
  - Magnitudes are held in WIDTH-bit unsigned form, so the most-negative value maps to 2^(WIDTH-1) without overflow.
  - In unsigned mode the magnitudes are the raw operands.
- CALC:
  - Each edge: if the current multiplier LSB is 1, add the multiplicand, shifted by count, into the 2*WIDTH accumulator. Then shift the multiplier right and increment count.
  - After exactly WIDTH CALC edges (count reaches WIDTH), go to FIN.
- FIN, one edge:
  - product <= neg ? -accumulator (two's complement, 2*WIDTH bits) : accumulator.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start is sampled at edge 0. The CALC edges are 1..WIDTH. product updates and done rises at edge WIDTH+1. done drops at edge WIDTH+2.
- Back-to-back: start may be high in the cycle where done=1. It is accepted at that edge: done falls, busy rises, and product keeps the previous result.
- start while busy=1 is ignored. Operands and signed_mode are not re-sampled, and the operation in flight is unaffected.
- Inputs a, b and signed_mode may change freely after the start edge without effect.
- Arithmetic is exact: no truncation or saturation. The full 2*WIDTH result always fits for both modes.
- A zero operand still takes the full WIDTH+1 cycles; no early termination.
- product changes only at FIN edges or on reset.

Test Plan:
- WIDTH=4, unsigned: a=0110, b=1110, start for one cycle -> busy high 5 cycles; done at edge 5 after start; product=8'h54 (84).
- WIDTH=4, signed: a=0110, b=1110 (6 x -2) -> product=8'hF4 (-12). Then a=1000, b=1000 (-8 x -8) -> 8'h40. Then a=1000, b=0111 (-8 x 7) -> 8'hC8.
- WIDTH=4, unsigned: corner cases 1111 x 1111 -> 8'hE1; 0000 x 1011 -> 8'h00, with done still at edge 5.
- Back-to-back: hold start high through the done cycle with new operands 0111 x 0101 unsigned.
  - First product is visible in the done cycle.
  - Second done arrives exactly 5 edges later with 8'h23.
  - busy stays low only for the done cycle.
- Busy-ignore: pulse start with 0010 x 0110 at cycle 2 of an operation running 0111 x 0011 -> single done with 8'h15; no second done.
- Reset: assert rst asynchronously (mid-cycle) during CALC -> busy, done and product go to 0 immediately without waiting for a clock edge; no done after release. A fresh start then completes normally.
- Run WIDTH=8 with random signed and unsigned operands against a reference model, checking done timing at edge 9.
